// File: rtl/lut_cfg_loader_if.sv
// Serial LUT configuration bus: load request, bit stream in, truth table out.
// Latency: n/a (signal bundle only).
// Backpressure: cfg_valid/cfg_ready handshake; a bit moves only when both are high.
//
// master: the configuration source (drives start/cfg_valid/cfg_data).
// slave : the loader (drives cfg_ready, config_out, cen, status and chain forward).
interface lut_cfg_loader_if #(
    parameter int MEM_SIZE = 16
);
    logic                start;
    logic                cfg_valid;
    logic                cfg_data;
    logic                cfg_ready;
    logic [MEM_SIZE-1:0] config_out;
    logic                cen;
    logic                busy;
    logic                done;
    logic                chain_valid;
    logic                chain_data;

    modport master (
        output start, cfg_valid, cfg_data,
        input  cfg_ready, config_out, cen, busy, done, chain_valid, chain_data
    );

    modport slave (
        input  start, cfg_valid, cfg_data,
        output cfg_ready, config_out, cen, busy, done, chain_valid, chain_data
    );
endinterface

// File: rtl/lut_cfg_loader.sv
// Shifts a serial truth table (LSB first) into a LUT config register, then strobes cen once.
// Latency: last bit accepted at edge N -> cen high N..N+1 -> done from N+1; chain forward 1 cycle.
// Backpressure: cfg_ready low in IDLE/COMMIT and on a restart cycle in DONE; gaps in cfg_valid stall.
//
// Ports: cclk clock, rst_n async active-low reset, bus (slave side of lut_cfg_loader_if):
//   start/cfg_valid/cfg_data in; cfg_ready, config_out, cen, busy, done, chain_valid, chain_data out.
module lut_cfg_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS
) (
    input  logic             cclk,
    input  logic             rst_n,
    lut_cfg_loader_if.slave  bus
);
    localparam int CW = $clog2(MEM_SIZE) + 1;

    // A truth table can neither exceed the LUT address space nor leave the supported range.
    if (MEM_SIZE < 2 || MEM_SIZE > 256 || MEM_SIZE > 2**INPUTS) begin : g_bad_mem_size
        $error("lut_cfg_loader: MEM_SIZE out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [MEM_SIZE-1:0] sr;
    logic [CW-1:0]       cnt;
    logic                chain_valid_q;
    logic                chain_data_q;
    logic                cfg_ready;
    logic                accept;
    logic                load_start;
    logic                last_bit;

    assign accept     = bus.cfg_valid & cfg_ready;
    assign load_start = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last_bit   = (cnt == CW'(MEM_SIZE - 1));

    // State register
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (accept && last_bit) state_nxt = COMMIT;
            COMMIT:  state_nxt = DONE;
            DONE:    if (bus.start) state_nxt = SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; only cfg_ready looks at an input (start, in DONE) so a restart
    // cycle never swallows or forwards a bit.
    always_comb begin
        cfg_ready = 1'b0;
        bus.cen   = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            SHIFT: begin
                cfg_ready = 1'b1;
                bus.busy  = 1'b1;
            end
            COMMIT: begin
                bus.cen  = 1'b1;
                bus.busy = 1'b1;
            end
            DONE: begin
                cfg_ready = ~bus.start;
                bus.done  = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift register and bit counter. The counter has one spare bit so it never
    // wraps within a load; leaving SHIFT on the last bit stops it at MEM_SIZE.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load_start) begin
            sr  <= '0;
            cnt <= '0;
        end else if ((state == SHIFT) && accept) begin
            sr  <= {bus.cfg_data, sr[MEM_SIZE-1:1]};
            cnt <= cnt + CW'(1);
        end
    end

    // Daisy-chain forward: once this LUT is configured, further bits pass through
    // to the next loader one cycle later. chain_data holds between forwards.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            chain_valid_q <= 1'b0;
            chain_data_q  <= 1'b0;
        end else begin
            chain_valid_q <= (state == DONE) && accept;
            if ((state == DONE) && accept) begin
                chain_data_q <= bus.cfg_data;
            end
        end
    end

    assign bus.cfg_ready   = cfg_ready;
    assign bus.config_out  = sr;
    assign bus.chain_valid = chain_valid_q;
    assign bus.chain_data  = chain_data_q;
endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader with MEM_SIZE=4, INPUTS=2.
// Expected truth tables and forwarded chain bits are queued when stimulus is
// driven and compared by a monitor when cen / chain_valid appear.
module tb_lut_cfg_loader;
    logic cclk  = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cen_cnt  = 0;
    int chain_cnt = 0;

    logic [3:0] exp_cfg_q[$];
    logic       exp_chain_q[$];

    always #5 cclk = ~cclk;

    lut_cfg_loader_if #(.MEM_SIZE(4)) bus ();

    lut_cfg_loader #(
        .INPUTS   (2),
        .MEM_SIZE (4)
    ) dut (
        .cclk  (cclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample on the falling edge, away from input changes and state updates.
    always @(negedge cclk) begin
        if (rst_n) begin
            if (bus.cen === 1'b1) begin
                cen_cnt++;
                if (exp_cfg_q.size() == 0) begin
                    chk("cen_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("config_at_cen", 32'(bus.config_out), 32'(exp_cfg_q.pop_front()));
                end
            end
            if (bus.chain_valid === 1'b1) begin
                chain_cnt++;
                if (exp_chain_q.size() == 0) begin
                    chk("chain_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("chain_data", 32'(bus.chain_data), 32'(exp_chain_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic d);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n, input logic pulse_start);
        for (int i = 0; i < n; i++) begin
            bus.start = pulse_start;
            #1;
            chk("gap_busy", 32'(bus.busy), 32'd1);
            chk("gap_ready", 32'(bus.cfg_ready), 32'd1);
            tick();
            bus.start = 1'b0;
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 1'b0;

        // Reset state, before any clock edge
        #3;
        chk("rst_config", 32'(bus.config_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cen", 32'(bus.cen), 32'd0);
        chk("rst_chain_valid", 32'(bus.chain_valid), 32'd0);
        chk("rst_chain_data", 32'(bus.chain_data), 32'd0);
        chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // cfg_valid in IDLE is ignored
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 1'b1;
        #1;
        chk("idle_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        tick();
        bus.cfg_valid = 1'b0;
        chk("idle_config", 32'(bus.config_out), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Back-to-back load 1,0,1,1 -> 4'b1101
        exp_cfg_q.push_back(4'b1101);
        do_start();
        chk("shift_busy", 32'(bus.busy), 32'd1);
        chk("shift_ready", 32'(bus.cfg_ready), 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("commit_cen", 32'(bus.cen), 32'd1);
        chk("commit_ready", 32'(bus.cfg_ready), 32'd0);
        chk("commit_done", 32'(bus.done), 32'd0);
        tick();
        chk("done_cen", 32'(bus.cen), 32'd0);
        chk("done_done", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("b2b_config", 32'(bus.config_out), 32'hD);
        chk("b2b_cen_count", 32'(cen_cnt), 32'd1);

        // Daisy chain: 1 then 0 forwarded, LUT contents untouched
        exp_chain_q.push_back(1'b1);
        exp_chain_q.push_back(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        tick();
        chk("chain_idle_valid", 32'(bus.chain_valid), 32'd0);
        chk("chain_hold_data", 32'(bus.chain_data), 32'd0);
        chk("chain_count", 32'(chain_cnt), 32'd2);
        chk("chain_config", 32'(bus.config_out), 32'hD);
        chk("chain_cen_count", 32'(cen_cnt), 32'd1);

        // Restart from DONE with a bit presented on the same cycle
        bus.start     = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 1'b1;
        #1;
        chk("restart_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_cleared", 32'(bus.config_out), 32'd0);
        tick();
        chk("restart_no_forward", 32'(chain_cnt), 32'd2);
        exp_cfg_q.push_back(4'b0000);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        tick();
        chk("zero_config", 32'(bus.config_out), 32'd0);
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_cen_count", 32'(cen_cnt), 32'd2);

        // Gapped load 0,1,1,0 with start pulses inside a gap -> 4'b0110
        exp_cfg_q.push_back(4'b0110);
        do_start();
        send_bit(1'b0);
        idle_gap(2, 1'b1);
        send_bit(1'b1);
        chk("gap_partial", 32'(bus.config_out), 32'h8);
        idle_gap(2, 1'b0);
        send_bit(1'b1);
        idle_gap(2, 1'b0);
        send_bit(1'b0);
        chk("gap_commit_cen", 32'(bus.cen), 32'd1);
        tick();
        chk("gap_config", 32'(bus.config_out), 32'h6);
        chk("gap_done", 32'(bus.done), 32'd1);
        chk("gap_cen_count", 32'(cen_cnt), 32'd3);

        // Reset mid-load aborts without cen, then a clean reload
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_config", 32'(bus.config_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_cen", 32'(bus.cen), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);
        chk("abort_cen_count", 32'(cen_cnt), 32'd3);
        exp_cfg_q.push_back(4'b1111);
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick();
        chk("reload_config", 32'(bus.config_out), 32'hF);
        chk("reload_done", 32'(bus.done), 32'd1);
        chk("reload_cen_count", 32'(cen_cnt), 32'd4);

        tick();
        chk("cfg_queue_drained", 32'(exp_cfg_q.size()), 32'd0);
        chk("chain_queue_drained", 32'(exp_chain_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lut_cfg_loader.md
LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

Interface
REQ-001 Parameter INPUTS, default 4, is the LUT address width.
REQ-002 Parameter MEM_SIZE, default 2**INPUTS, is the LUT truth-table bit count; legal range is 2..256.
REQ-003 cclk  in  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  is the reset, asynchronous and active-low.
REQ-005 start  in  1  requests a new load; it is sampled only in IDLE and DONE.
REQ-006 cfg_valid  in  1  marks a serial config bit as valid.
REQ-007 cfg_data  in  1  is the serial config bit, LSB of the truth table first.
REQ-008 cfg_ready  out  1  means the block accepts a bit this cycle.
REQ-009 config_out  out  MEM_SIZE  is the parallel truth table for the downstream memory LUT config_in.
REQ-010 cen  out  1  is a one-cycle commit strobe for the downstream LUT cen.
REQ-011 busy  out  1  is high in SHIFT and COMMIT.
REQ-012 done  out  1  is high in DONE.
REQ-013 chain_valid  out  1  is the daisy-chain forward valid.
REQ-014 chain_data  out  1  is the daisy-chain forward bit.

Function
REQ-015 The state machine has four states: IDLE, SHIFT, COMMIT, DONE.
REQ-016 A bit is accepted on a cycle only when cfg_valid=1 and cfg_ready=1.
REQ-017 In IDLE, cfg_ready=0 and cfg_valid is ignored.
- start=1 moves to SHIFT.
- The shift register and bit counter clear on that transition.
REQ-018 In SHIFT, cfg_ready=1.
- Each accepted bit shifts in at the MSB: sr <= {cfg_data, sr[MEM_SIZE-1:1]}.
- The counter increments by 1 per accepted bit.
REQ-019 The counter is $clog2(MEM_SIZE)+1 bits wide and never wraps; a load is exactly MEM_SIZE accepted bits.
REQ-020 When the accepted bit is bit number MEM_SIZE-1 (counter==MEM_SIZE-1), the next state is COMMIT.
REQ-021 In SHIFT, gaps in cfg_valid stall the shift with no state change.
- start is ignored in SHIFT.
REQ-022 COMMIT lasts exactly one cycle.
- cen=1 and cfg_ready=0.
- Next state is DONE unconditionally.
REQ-023 cen is high only in COMMIT.
REQ-024 Latency: last bit accepted at edge N -> cen high from edge N to N+1 -> done high from edge N+1.
REQ-025 config_out is the shift-register contents at all times.
- It changes only on accepted bits in SHIFT and on the clear at load start.
- It holds stable in COMMIT and DONE.
REQ-026 The first transmitted bit lands in config_out[0] and the last in config_out[MEM_SIZE-1].
REQ-027 In DONE, cfg_ready=1.
- Each accepted bit is forwarded next cycle: chain_valid=1, chain_data=cfg_data.
- Otherwise chain_valid=0 next cycle.
- config_out is unaffected.
REQ-028 In DONE, start=1 moves to SHIFT and clears sr and the counter.
- A bit presented in that same cycle is neither accepted nor forwarded (cfg_ready=0 when start=1 in DONE).
REQ-029 chain_valid is 0 in all states except the cycle after a DONE-state acceptance.
- chain_data holds its last value when chain_valid=0.
REQ-030 busy and done are decoded directly from registered state, with no combinational path from inputs.
- cfg_ready may depend combinationally on start in DONE only (REQ-028).

Reset
REQ-031 rst_n=0 forces immediately, regardless of cclk:
- state IDLE, sr=0, counter=0;
- config_out=0, cen=0, busy=0, done=0;
- chain_valid=0, chain_data=0.
REQ-032 Reset asserted mid-SHIFT or in COMMIT aborts the load with no cen pulse.
- The first rising edge after rst_n=1 evaluates IDLE rules.

Verification (MEM_SIZE=4, INPUTS=2)
REQ-033 Back-to-back load: reset, start, then bits 1,0,1,1 on consecutive cycles -> config_out=4'b1101, cen=1 for exactly one cycle the cycle after the 4th bit, done=1 the following cycle.
REQ-034 Gapped load: bits 0,1,1,0 with cfg_valid low 2 cycles between each bit -> config_out=4'b0110, busy=1 throughout the gaps, single cen pulse.
REQ-035 Daisy chain: after REQ-033, send bits 1,0 -> chain_valid=1 on two cycles with chain_data 1 then 0; config_out stays 4'b1101; cen stays 0.
REQ-036 Mid-load reset: 2 bits accepted, then rst_n=0 -> config_out=0, busy=0, no cen. Reload 1,1,1,1 -> config_out=4'b1111.
REQ-037 Ignored inputs:
- cfg_valid=1 in IDLE -> cfg_ready=0, nothing shifted.
- start pulse during SHIFT -> no change.
- start in DONE, then 0,0,0,0 -> config_out=4'b0000 and a new cen pulse.
